// File: rtl/flex_updown_counter.sv
// Up/down counter over 1..rollover_val with programmable width, wrap or saturate at the ends,
// synchronous clear/load, and status flags registered from the next-state value.
module flex_updown_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    bottom_flag,
    output logic                    wrap_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    rollover_q, rollover_d;
    logic                    bottom_q, bottom_d;
    logic                    wrap_q, wrap_d;

    logic range_valid;
    logic at_top;
    logic at_bottom;

    assign range_valid = (rollover_val != ZERO);
    assign at_top      = (count_q >= rollover_val);
    assign at_bottom   = (count_q <= ONE);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = ZERO;
        end else if (load) begin
            count_d = load_val;
        end else if (count_enable && range_valid) begin
            // End-of-range checks come first, so +1/-1 below never overflow or underflow.
            if (!count_down) begin
                if (at_top) begin
                    if (SATURATE) begin
                        count_d = count_q;
                    end else begin
                        count_d = ONE;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_bottom) begin
                    if (SATURATE) begin
                        count_d = count_q;
                    end else begin
                        count_d = rollover_val;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end

        // Flags derive from the next count so they line up with count_out.
        rollover_d = (count_d == rollover_val) && range_valid;
        bottom_d   = (count_d == ONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q    <= ZERO;
            rollover_q <= 1'b0;
            bottom_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
            bottom_q   <= bottom_d;
            wrap_q     <= wrap_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = rollover_q;
    assign bottom_flag   = bottom_q;
    assign wrap_pulse    = wrap_q;

endmodule
